// File: rtl/cpu_defs.sv
// cpu_defs: shared fetch address map and PC defaults for CP0 and next-PC logic
package cpu_defs;
    localparam int unsigned WIDTH_D = 32;
    localparam logic [31:0] RESET_VEC_D = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_D = 32'h0000_4180;
    localparam int unsigned STEP_D = 4;
    localparam logic [31:0] IMEM_LO_D = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI_D = 32'h0000_6FFC;
endpackage

// File: rtl/pc_pend_buf.sv
// pc_pend_buf: one-deep buffer holding a redirect that arrived while fetch was stalled
import cpu_defs::*;
module pc_pend_buf #(
    parameter int unsigned WIDTH = WIDTH_D
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             capture,
    input  logic             consume,
    input  logic [WIDTH-1:0] target,
    output logic             pend_valid,
    output logic [WIDTH-1:0] pend_target
);
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_target <= '0;
        end else if (flush) begin
            pend_valid <= 1'b0;
        end else if (capture) begin
            pend_valid <= 1'b1;
            pend_target <= target;
        end else if (consume) begin
            pend_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage PC register with prioritised next-PC select and fetch address fault flag
import cpu_defs::*;
module pc_gen #(
    parameter int unsigned      WIDTH     = WIDTH_D,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_D),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_D),
    parameter int unsigned      STEP      = STEP_D,
    parameter logic [WIDTH-1:0] IMEM_LO   = WIDTH'(IMEM_LO_D),
    parameter logic [WIDTH-1:0] IMEM_HI   = WIDTH'(IMEM_HI_D)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    output logic [WIDTH-1:0] pc,
    output logic             pend_valid,
    output logic             adel
);
    logic [WIDTH-1:0] pend_target;
    logic [WIDTH-1:0] pc_next;

    // any unstalled edge either uses or supersedes the buffered redirect
    pc_pend_buf #(.WIDTH(WIDTH)) u_pend (
        .clk(clk),
        .reset(reset),
        .flush(req | eret),
        .capture(stall & redir_valid),
        .consume(~stall),
        .target(redir_target),
        .pend_valid(pend_valid),
        .pend_target(pend_target)
    );

    always_comb begin
        pc_next = req ? EXC_VEC :
                  eret ? epc :
                  stall ? pc :
                  redir_valid ? redir_target :
                  pend_valid ? pend_target : pc + WIDTH'(STEP);
        adel = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
    end

    always_ff @(posedge clk) begin
        if (!reset) pc <= RESET_VEC;
        else pc <= pc_next;
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen
module tb_pc_gen;
    logic clk = 1'b0;
    logic reset, stall, req, eret, redir_valid;
    logic [31:0] epc, redir_target, pc;
    logic pend_valid, adel;
    int checks = 0;
    int errors = 0;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .pc(pc), .pend_valid(pend_valid), .adel(adel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] epc_v, input logic epv, input logic ead);
        checks++;
        assert (pc === epc_v) else begin
            errors++;
            $error("FAIL %s pc got %h want %h", tag, pc, epc_v);
        end
        checks++;
        assert (pend_valid === epv) else begin
            errors++;
            $error("FAIL %s pend_valid got %b want %b", tag, pend_valid, epv);
        end
        checks++;
        assert (adel === ead) else begin
            errors++;
            $error("FAIL %s adel got %b want %b", tag, adel, ead);
        end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; req = 1'b0; eret = 1'b0; redir_valid = 1'b0;
        epc = '0; redir_target = '0;
        step(); step();
        chk("reset", 32'h3000, 1'b0, 1'b0);
        reset = 1'b1;
        step(); chk("seq1", 32'h3004, 1'b0, 1'b0);
        step(); chk("seq2", 32'h3008, 1'b0, 1'b0);
        step(); chk("seq3", 32'h300C, 1'b0, 1'b0);
        step(); chk("seq4", 32'h3010, 1'b0, 1'b0);
        stall = 1'b1;
        step(); chk("stall1", 32'h3010, 1'b0, 1'b0);
        redir_valid = 1'b1; redir_target = 32'h3400;
        step(); chk("stall2_cap", 32'h3010, 1'b1, 1'b0);
        redir_valid = 1'b0;
        step(); chk("stall3_hold", 32'h3010, 1'b1, 1'b0);
        stall = 1'b0;
        step(); chk("pend_use", 32'h3400, 1'b0, 1'b0);
        step(); chk("pend_seq", 32'h3404, 1'b0, 1'b0);
        req = 1'b1; stall = 1'b1; eret = 1'b1; epc = 32'h3020;
        redir_valid = 1'b1; redir_target = 32'h3200;
        step(); chk("req_prio", 32'h4180, 1'b0, 1'b0);
        req = 1'b0; eret = 1'b0; redir_target = 32'h3300;
        step(); chk("cap_again", 32'h4180, 1'b1, 1'b0);
        redir_valid = 1'b0; eret = 1'b1;
        step(); chk("eret_prio", 32'h3020, 1'b0, 1'b0);
        eret = 1'b0; stall = 1'b0;
        step(); chk("eret_seq", 32'h3024, 1'b0, 1'b0);
        redir_valid = 1'b1; redir_target = 32'h3402;
        step(); chk("misalign", 32'h3402, 1'b0, 1'b1);
        redir_target = 32'h7000;
        step(); chk("above_hi", 32'h7000, 1'b0, 1'b1);
        redir_target = 32'h6FFC;
        step(); chk("at_hi", 32'h6FFC, 1'b0, 1'b0);
        redir_valid = 1'b0;
        step(); chk("past_hi", 32'h7000, 1'b0, 1'b1);
        stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h3500;
        step(); chk("pre_reset_pend", 32'h7000, 1'b1, 1'b1);
        redir_valid = 1'b0; reset = 1'b0;
        step(); chk("reset_pend", 32'h3000, 1'b0, 1'b0);
        reset = 1'b1; stall = 1'b0; redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
        step(); chk("top_addr", 32'hFFFF_FFFC, 1'b0, 1'b1);
        redir_valid = 1'b0;
        step(); chk("wrap", 32'h0000_0000, 1'b0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
